// File: rtl/ps2tx.sv
// ps2tx - host-to-device PS/2 transmitter.
//
// Serializes one command byte onto an open-drain PS/2 clock/data pair and
// checks the device acknowledge. The enables are active-high "pull low"
// controls; the board top ORs them with those of any receiver on the pins.
//
// Parameters
//   CLKFREQ    system clock frequency in kHz
//   INHIBIT_US clock-inhibit time before the start bit, in us
//   TIMEOUT_MS watchdog limit in ms (only with PS2TX_TIMEOUT_EN)
//
// Ports
//   clock        system clock
//   reset        asynchronous active-low reset; releases the bus at once
//   strb, data   send request and command byte
//   ps2Ck, ps2DQ PS/2 pin levels (asynchronous)
//   ckOe, dqOe   1 = drive pin low, 0 = release
//   busy         transfer in progress (cycle after strb through done)
//   done         one-cycle pulse at end of transfer
//   error        no acknowledge or timeout; valid with done, held to next strb
//   o_dbg_state  current FSM state, for observation only
//
// Handshake: strb is a one-cycle request with no ready. It is accepted only
// in IDLE; a strb seen in any other state (including the done cycle) is
// dropped, nothing is queued.
//
// Optional feature: define PS2TX_TIMEOUT_EN to add a watchdog that aborts a
// transfer with error=1 if the device stops clocking.

module ps2tx #(
    parameter int CLKFREQ    = 32000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       strb,
    input  logic [7:0] data,
    input  logic       ps2Ck,
    input  logic       ps2DQ,
    output logic       ckOe,
    output logic       dqOe,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] o_dbg_state
);

    localparam int INH_LOAD = CLKFREQ * INHIBIT_US / 1000;
    localparam int CNT_W    = $clog2(INH_LOAD + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INHIBIT = 3'd1,
        S_REQ     = 3'd2,
        S_SEND    = 3'd3,
        S_ACK     = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic               r_ck_s1, r_ck_s2;
    logic               r_dq_s1, r_dq_s2;
    logic [3:0]         r_ck_hist;
    logic               r_ck_f;
    logic               r_fall;
    logic [3:0]         w_hist_next;

    logic [7:0]         r_shf;
    logic               r_par;
    logic               r_error;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_bit;
    logic               r_dq_oe;

    logic               w_inh_done;
    logic               w_active;
    logic               w_timeout;

    // ------------------------------------------------------------------
    // Input conditioning: 2-FF synchronizers, then a 4-sample filter on
    // the clock so a glitch shorter than 4 cycles never produces a fall.
    // Lines reset to 1, the idle bus level.
    // ------------------------------------------------------------------
    assign w_hist_next = {r_ck_hist[2:0], r_ck_s2};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ck_s1   <= 1'b1;
            r_ck_s2   <= 1'b1;
            r_dq_s1   <= 1'b1;
            r_dq_s2   <= 1'b1;
            r_ck_hist <= 4'hF;
            r_ck_f    <= 1'b1;
            r_fall    <= 1'b0;
        end else begin
            r_ck_s1   <= ps2Ck;
            r_ck_s2   <= r_ck_s1;
            r_dq_s1   <= ps2DQ;
            r_dq_s2   <= r_dq_s1;
            r_ck_hist <= w_hist_next;
            if (w_hist_next == 4'h0) begin
                r_ck_f <= 1'b0;
            end else if (w_hist_next == 4'hF) begin
                r_ck_f <= 1'b1;
            end
            // Single-cycle pulse: r_ck_f drops on the same edge.
            r_fall <= r_ck_f && (w_hist_next == 4'h0);
        end
    end

    // Inhibit ends on the edge where the count would reach zero, so ckOe is
    // high for exactly INH_LOAD cycles.
    assign w_inh_done = (r_state == S_INHIBIT) && (r_cnt <= CNT_W'(1));
    assign w_active   = (r_state == S_REQ) || (r_state == S_SEND) ||
                        (r_state == S_ACK);

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef PS2TX_TIMEOUT_EN
    localparam int WD_LOAD = CLKFREQ * TIMEOUT_MS;
    localparam int WD_W    = $clog2(WD_LOAD + 1);

    logic [WD_W-1:0] r_wd;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wd <= '0;
        end else if (w_inh_done) begin
            r_wd <= WD_W'(WD_LOAD);
        end else if (w_active && (r_wd != '0)) begin
            r_wd <= r_wd - WD_W'(1);
        end
    end

    assign w_timeout = w_active && (r_wd == '0);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_MS != 0);
    assign w_timeout    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs. The enables are decoded from the state
    // so an asynchronous reset releases the bus without a clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        ckOe   = 1'b0;
        dqOe   = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (strb) begin
                    w_next = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                ckOe = 1'b1;
                if (w_inh_done) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                dqOe = r_dq_oe;
                if (r_fall) begin
                    w_next = S_SEND;
                end
            end
            S_SEND: begin
                dqOe = r_dq_oe;
                // 11th falling edge: device should be holding data low.
                if (r_fall && (r_bit == 4'd10)) begin
                    w_next = r_dq_s2 ? S_FINISH : S_ACK;
                end
            end
            S_ACK: begin
                if (r_ck_f && r_dq_s2) begin
                    w_next = S_FINISH;
                end
            end
            S_FINISH: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
        if (w_timeout) begin
            w_next = S_FINISH;
            ckOe   = 1'b0;
            dqOe   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: shift byte, parity, inhibit counter, bit index, data drive.
    // The first fall (taken in REQ with r_bit=0) places data bit 0; the
    // start bit was already on the line since leaving INHIBIT.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shf   <= 8'h00;
            r_par   <= 1'b0;
            r_error <= 1'b0;
            r_cnt   <= '0;
            r_bit   <= 4'd0;
            r_dq_oe <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_dq_oe <= 1'b0;
                    if (strb) begin
                        r_shf   <= data;
                        r_par   <= ~^data;
                        r_error <= 1'b0;
                        r_cnt   <= CNT_W'(INH_LOAD);
                    end
                end
                S_INHIBIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                    if (w_inh_done) begin
                        r_dq_oe <= 1'b1;
                        r_bit   <= 4'd0;
                    end
                end
                S_REQ, S_SEND: begin
                    if (r_fall) begin
                        if (r_bit == 4'd10) begin
                            if (r_dq_s2) begin
                                r_error <= 1'b1;
                            end
                        end else begin
                            if (r_bit < 4'd8) begin
                                r_dq_oe <= ~r_shf[r_bit[2:0]];
                            end else if (r_bit == 4'd8) begin
                                r_dq_oe <= ~r_par;
                            end else begin
                                r_dq_oe <= 1'b0;
                            end
                            r_bit <= r_bit + 4'd1;
                        end
                    end
                end
                default: begin
                    r_dq_oe <= 1'b0;
                end
            endcase
            if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    assign error       = r_error;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ps2tx.sv
// Testbench for ps2tx: a behavioural PS/2 device drives the clock and reads
// the frame on its rising edges; a frame model built from the byte (start,
// LSB-first data, odd parity, stop) fills an expected queue.

module tb_ps2tx;

    localparam int HALF     = 30;    // device clock half period, in cycles
    localparam int INH_EXP  = 3200;  // 32000 kHz * 100 us / 1000

    logic       clock;
    logic       reset;
    logic       strb;
    logic [7:0] data;
    logic       ps2Ck;
    logic       ps2DQ;
    logic       ckOe;
    logic       dqOe;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] dbg_state;

    logic       dev_ck_low;
    logic       dev_dq_low;

    // Open-drain bus: either side pulling low wins.
    assign ps2Ck = ~(ckOe | dev_ck_low);
    assign ps2DQ = ~(dqOe | dev_dq_low);

    ps2tx dut (
        .clock       (clock),
        .reset       (reset),
        .strb        (strb),
        .data        (data),
        .ps2Ck       (ps2Ck),
        .ps2DQ       (ps2DQ),
        .ckOe        (ckOe),
        .dqOe        (dqOe),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / time limit ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
`ifdef PS2TX_TIMEOUT_EN
        #20000000;
`else
        #3000000;
`endif
        $display("FAIL time_limit actual=running required=finished");
        $fatal(1, "time limit");
    end

    // ---------------- scoreboard ----------------
    int         checks;
    int         failures;
    logic [0:0] exp_q[$];
    logic [10:0] seen_frame;

    bit         mon_on;
    bit         seen_done;
    bit         busy_bad;
    int         done_cnt;
    logic       err_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame as the device should see it, from the byte alone.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        int          ones;
        logic [10:0] f;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // One cycle, sampled on the falling edge; tracks busy/done/error.
    task automatic tick();
        @(negedge clock);
        if (mon_on) begin
            if (!seen_done && busy !== 1'b1) busy_bad = 1'b1;
            if (done === 1'b1) begin
                done_cnt++;
                err_seen  = error;
                seen_done = 1'b1;
            end
        end
    endtask

    task automatic mon_start();
        mon_on    = 1'b1;
        seen_done = 1'b0;
        busy_bad  = 1'b0;
        done_cnt  = 0;
        err_seen  = 1'b0;
    endtask

    // strb, then measure the inhibit window; leaves the bench at the first
    // cycle of the request-to-send phase.
    task automatic start_and_inhibit(input logic [7:0] d);
        int cnt;
        mon_start();
        data = d;
        strb = 1'b1;
        tick();
        strb = 1'b0;
        cnt  = 0;
        while (ckOe === 1'b1 && cnt < 5000) begin
            cnt++;
            tick();
        end
        check("inhibit_len", cnt, INH_EXP);
        check("req_enables", {30'd0, ckOe, dqOe}, 32'd1);
    endtask

    // Full transfer with the device model. strb_fall / rst_fall select the
    // fall at which a stray strb or a reset is injected (0 = none).
    task automatic run_xfer(input logic [7:0] d, input bit ack,
                            input int strb_fall, input int rst_fall);
        logic [10:0] fr;
        int          cnt;
        fr = model_frame(d);
        exp_q.delete();
        for (int i = 0; i < 11; i++) exp_q.push_back(fr[i]);

        start_and_inhibit(d);
        seen_frame[0] = ps2DQ;
        check("start_bit", {31'd0, ps2DQ}, {31'd0, exp_q.pop_front()});

        for (int f = 1; f <= 11; f++) begin
            repeat (HALF) tick();
            if (f == 11 && ack) dev_dq_low = 1'b1;
            dev_ck_low = 1'b1;
            if (f == rst_fall) begin
                repeat (3) tick();
                reset = 1'b0;
                #1;
                check("reset_async", {27'd0, ckOe, dqOe, busy, done, error}, 32'd0);
                dev_ck_low = 1'b0;
                dev_dq_low = 1'b0;
                repeat (4) tick();
                reset = 1'b1;
                repeat (4) tick();
                mon_on = 1'b0;
                return;
            end
            if (f == strb_fall) begin
                data = 8'h00;
                strb = 1'b1;
                tick();
                strb = 1'b0;
            end
            repeat (HALF) tick();
            if (f <= 10) begin
                seen_frame[f] = ps2DQ;
                check($sformatf("frame_bit%0d", f), {31'd0, ps2DQ}, {31'd0, exp_q.pop_front()});
            end
            dev_ck_low = 1'b0;
            if (f == 11) dev_dq_low = 1'b0;
        end

        cnt = 0;
        while (!seen_done && cnt < 200) begin
            cnt++;
            tick();
        end
        check("done_seen", {31'd0, seen_done}, 32'd1);
        check("done_count", done_cnt, 32'd1);
        check("done_error", {31'd0, err_seen}, {31'd0, !ack});
        check("busy_span", {31'd0, busy_bad}, 32'd0);
        repeat (10) tick();
        check("idle_after", {28'd0, ckOe, dqOe, busy, done}, 32'd0);
        mon_on = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] d;
        bit         ack;
        logic       exp_par;
        logic       exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] rd;
        bit         rack;

        checks     = 0;
        failures   = 0;
        mon_on     = 1'b0;
        reset      = 1'b0;
        strb       = 1'b0;
        data       = 8'h00;
        dev_ck_low = 1'b0;
        dev_dq_low = 1'b0;

        vecs[0] = '{d: 8'hF4, ack: 1'b1, exp_par: 1'b0, exp_err: 1'b0};
        vecs[1] = '{d: 8'hFF, ack: 1'b0, exp_par: 1'b1, exp_err: 1'b1};
        vecs[2] = '{d: 8'h00, ack: 1'b1, exp_par: 1'b1, exp_err: 1'b0};
        vecs[3] = '{d: 8'hA5, ack: 1'b1, exp_par: 1'b1, exp_err: 1'b0};
        vecs[4] = '{d: 8'h80, ack: 1'b0, exp_par: 1'b0, exp_err: 1'b1};
        vecs[5] = '{d: 8'h7E, ack: 1'b1, exp_par: 1'b1, exp_err: 1'b0};

        // Reset state
        repeat (5) tick();
        check("reset_outputs", {27'd0, ckOe, dqOe, busy, done, error}, 32'd0);
        check("reset_state", {29'd0, dbg_state}, 32'd0);
        reset = 1'b1;
        repeat (10) tick();
        check("idle_outputs", {27'd0, ckOe, dqOe, busy, done, error}, 32'd0);

        // Table-driven transfers
        for (int i = 0; i < 6; i++) begin
            run_xfer(vecs[i].d, vecs[i].ack, 0, 0);
            check($sformatf("tbl%0d_data", i), {24'd0, seen_frame[8:1]}, {24'd0, vecs[i].d});
            check($sformatf("tbl%0d_parity", i), {31'd0, seen_frame[9]}, {31'd0, vecs[i].exp_par});
            check($sformatf("tbl%0d_error", i), {31'd0, err_seen}, {31'd0, vecs[i].exp_err});
            check($sformatf("tbl%0d_stop", i), {31'd0, seen_frame[10]}, 32'd1);
        end

        // Stray strb with 0x00 at the 5th fall: ignored, first byte unchanged.
        run_xfer(8'hF4, 1'b1, 5, 0);
        check("strb_ignored_data", {24'd0, seen_frame[8:1]}, 32'hF4);

        // Reset at the 6th fall, then a normal transfer.
        run_xfer(8'hF4, 1'b1, 0, 6);
        check("after_reset_idle", {27'd0, ckOe, dqOe, busy, done, error}, 32'd0);
        run_xfer(8'hF4, 1'b1, 0, 0);

        // Randomized bytes against the frame model
        for (int i = 0; i < 4; i++) begin
            rd   = 8'($urandom_range(0, 255));
            rack = ($urandom_range(0, 3) != 0);
            run_xfer(rd, rack, 0, 0);
            check($sformatf("rand%0d_data", i), {24'd0, seen_frame[8:1]}, {24'd0, rd});
        end

        // Silent device: never clocks after the start bit.
        start_and_inhibit(8'h3C);
        repeat (2000) tick();
`ifdef PS2TX_TIMEOUT_EN
        begin
            int cnt;
            cnt = 2000;
            while (!seen_done && cnt < 490000) begin
                cnt++;
                tick();
            end
            check("timeout_done", {31'd0, seen_done}, 32'd1);
            check("timeout_window", {31'd0, (cnt >= 480000 && cnt <= 480003)}, 32'd1);
            check("timeout_error", {31'd0, err_seen}, 32'd1);
            check("timeout_enables", {30'd0, ckOe, dqOe}, 32'd0);
        end
`else
        check("silent_busy", {31'd0, busy}, 32'd1);
        check("silent_no_done", done_cnt, 32'd0);
        check("silent_start_held", {30'd0, ckOe, dqOe}, 32'd1);
`endif
        mon_on = 1'b0;
        reset  = 1'b0;
        repeat (3) tick();
        reset  = 1'b1;
        repeat (3) tick();
        check("silent_recovered", {27'd0, ckOe, dqOe, busy, done, error}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
